// File: rtl/led_pkg.sv
// Shared mode encodings and default timebase limits for the LED mode controller.
package led_pkg;

  localparam logic [2:0] MODE_OFF    = 3'd0;
  localparam logic [2:0] MODE_ON     = 3'd1;
  localparam logic [2:0] MODE_BLINK  = 3'd2;
  localparam logic [2:0] MODE_BREATH = 3'd3;
  localparam logic [2:0] MODE_FLOW   = 3'd4;
  localparam int         MODE_NUM    = 5;

  localparam logic [5:0] CNT_1US_DEF = 6'd49;
  localparam logic [9:0] CNT_1MS_DEF = 10'd999;
  localparam logic [9:0] CNT_1S_DEF  = 10'd999;

  // FLOW is the last mode; the sequence wraps back to OFF so 5..7 never appear.
  function automatic logic [2:0] next_mode(input logic [2:0] m);
    return (m == MODE_FLOW) ? MODE_OFF : m + 3'd1;
  endfunction

endpackage

// File: rtl/led_timebase.sv
// us / ms / s cascade counters with a one-second tick, breath direction and flow index.
module led_timebase
  import led_pkg::*;
#(
  parameter logic [5:0] CNT_1US_MAX = CNT_1US_DEF,
  parameter logic [9:0] CNT_1MS_MAX = CNT_1MS_DEF,
  parameter logic [9:0] CNT_1S_MAX  = CNT_1S_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       clr,
  output logic       sec_tick,
  output logic [9:0] ms_sub,
  output logic [9:0] ms_idx,
  output logic       dir,
  output logic [1:0] flow_idx
);

  logic [5:0] us_cnt;
  logic       us_wrap;
  logic       ms_wrap;

  assign us_wrap  = (us_cnt == CNT_1US_MAX);
  assign ms_wrap  = us_wrap && (ms_sub == CNT_1MS_MAX);
  assign sec_tick = ms_wrap && (ms_idx == CNT_1S_MAX);

  // clr outranks sec_tick so a new mode always starts at phase zero.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || clr) begin
      us_cnt   <= '0;
      ms_sub   <= '0;
      ms_idx   <= '0;
      dir      <= 1'b0;
      flow_idx <= 2'd0;
    end else begin
      us_cnt <= us_wrap ? '0 : us_cnt + 6'd1;
      if (us_wrap)
        ms_sub <= (ms_sub == CNT_1MS_MAX) ? '0 : ms_sub + 10'd1;
      if (ms_wrap)
        ms_idx <= (ms_idx == CNT_1S_MAX) ? '0 : ms_idx + 10'd1;
      if (sec_tick) begin
        dir      <= ~dir;
        flow_idx <= flow_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/led_mode_ctrl.sv
// Key-stepped LED mode FSM (off/on/blink/breath/flow) with registered active-low outputs.
module led_mode_ctrl
  import led_pkg::*;
#(
  parameter logic [5:0] CNT_1US_MAX = CNT_1US_DEF,
  parameter logic [9:0] CNT_1MS_MAX = CNT_1MS_DEF,
  parameter logic [9:0] CNT_1S_MAX  = CNT_1S_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_flag,
  output logic [3:0] led_out,
  output logic [2:0] mode
);

  logic       sec_tick;
  logic [9:0] ms_sub;
  logic [9:0] ms_idx;
  logic       dir;
  logic [1:0] flow_idx;
  logic       breath_on;
  logic [3:0] led_nxt;

  led_timebase #(
    .CNT_1US_MAX (CNT_1US_MAX),
    .CNT_1MS_MAX (CNT_1MS_MAX),
    .CNT_1S_MAX  (CNT_1S_MAX)
  ) u_tb (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (key_flag),
    .sec_tick  (sec_tick),
    .ms_sub    (ms_sub),
    .ms_idx    (ms_idx),
    .dir       (dir),
    .flow_idx  (flow_idx)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)    mode <= MODE_OFF;
    else if (key_flag) mode <= next_mode(mode);
  end

  // PWM duty ramps up with ms_idx, then mirrors it on the dimming half.
  assign breath_on = dir ? (ms_sub < (CNT_1S_MAX - ms_idx)) : (ms_sub < ms_idx);

  always_comb begin
    led_nxt = 4'b1111;
    case (mode)
      MODE_ON:     led_nxt = 4'b0000;
      MODE_BLINK:  led_nxt = dir ? 4'b1111 : 4'b0000;
      MODE_BREATH: led_nxt = breath_on ? 4'b0000 : 4'b1111;
      MODE_FLOW:   led_nxt = ~(4'b0001 << flow_idx);
      default:     led_nxt = 4'b1111;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) led_out <= 4'b1111;
    else            led_out <= led_nxt;
  end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl with a 32-clock second (1us=2, 1ms=8 clocks).
module tb_led_mode_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       key_flag = 1'b0;
  logic [3:0] led_out;
  logic [2:0] mode;

  led_mode_ctrl #(
    .CNT_1US_MAX (6'd1),
    .CNT_1MS_MAX (10'd3),
    .CNT_1S_MAX  (10'd3)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_flag  (key_flag),
    .led_out   (led_out),
    .mode      (mode)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [2:0] m;
    logic [3:0] led;
    bit         cnt0;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   bm = 0;   // mode the bench expects to be current
  int   bt = 0;   // clocks since the last clear (reset or key)

  // Expected LED pattern for a mode at t clocks after its clear.
  function automatic logic [3:0] exp_led(input int m, input int t);
    int         on_tbl[8] = '{0, 2, 4, 6, 6, 4, 2, 0};
    logic [3:0] one = 4'b0001;
    int         sec = t / 32;
    case (m)
      1: return 4'b0000;
      2: return (sec % 2 == 1) ? 4'b1111 : 4'b0000;
      3: return ((t % 8) < on_tbl[(t % 64) / 8]) ? 4'b0000 : 4'b1111;
      4: return ~(one << (sec % 4));
      default: return 4'b1111;
    endcase
  endfunction

  task automatic tick(input logic k, input logic r, input string tag);
    exp_t e;
    key_flag  = k;
    sys_rst_n = r;
    if (!r) begin
      e.m = 3'd0; e.led = 4'b1111; e.cnt0 = 1'b1;
      bm = 0; bt = 0;
    end else begin
      e.led = exp_led(bm, bt);
      if (k) begin
        bm = (bm == 4) ? 0 : bm + 1;
        bt = 0;
      end else begin
        bt++;
      end
      e.m = 3'(bm);
      e.cnt0 = k;
    end
    e.tag = tag;
    @(posedge sys_clk);
    #1;
    key_flag  = 1'b0;
    sys_rst_n = 1'b1;
    exp_q.push_back(e);
  endtask

  always @(negedge sys_clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      if (mode !== mon_e.m || led_out !== mon_e.led) begin
        n_bad++;
        $display("FAIL %s: got mode=%0d led=%b, want mode=%0d led=%b",
                 mon_e.tag, mode, led_out, mon_e.m, mon_e.led);
      end
      if (mon_e.cnt0) begin
        n_cmp++;
        if (dut.u_tb.us_cnt !== 6'd0 || dut.u_tb.ms_sub !== 10'd0 ||
            dut.u_tb.ms_idx !== 10'd0 || dut.u_tb.dir !== 1'b0 ||
            dut.u_tb.flow_idx !== 2'd0) begin
          n_bad++;
          $display("FAIL %s_clear: got us=%0d ms_sub=%0d ms_idx=%0d dir=%0d flow=%0d, want all 0",
                   mon_e.tag, dut.u_tb.us_cnt, dut.u_tb.ms_sub, dut.u_tb.ms_idx,
                   dut.u_tb.dir, dut.u_tb.flow_idx);
        end
      end
    end
  end

  initial begin
    #1;
    repeat (3) tick(1'b0, 1'b0, "reset");
    repeat (100) tick(1'b0, 1'b1, "idle");

    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, "key_seq");
      repeat (9) tick(1'b0, 1'b1, "key_seq");
    end

    tick(1'b1, 1'b1, "to_on");
    repeat (5) tick(1'b0, 1'b1, "on");
    tick(1'b1, 1'b1, "to_blink");
    repeat (130) tick(1'b0, 1'b1, "blink");
    tick(1'b1, 1'b1, "to_breath");
    repeat (70) tick(1'b0, 1'b1, "breath");

    // Step to the clock where sec_tick is high, then press the key into FLOW.
    for (int i = 0; i < 40 && (bt % 32) != 31; i++) tick(1'b0, 1'b1, "breath_align");
    n_cmp++;
    if ((bt % 32) != 31 || dut.sec_tick !== 1'b1) begin
      n_bad++;
      $display("FAIL sec_tick_align: got sec_tick=%0d phase=%0d, want 1 at phase 31",
               dut.sec_tick, bt % 32);
    end
    tick(1'b1, 1'b1, "flow_entry");
    repeat (70) tick(1'b0, 1'b1, "flow");

    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, "cycle_back");
      repeat (3) tick(1'b0, 1'b1, "cycle_back");
    end
    repeat (20) tick(1'b0, 1'b1, "breath2");
    tick(1'b1, 1'b0, "rst_mid");
    repeat (10) tick(1'b0, 1'b1, "post_rst");

    @(negedge sys_clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
